// File: rtl/dmem_be_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_be_ctrl_pkg
// Shared definitions for the MEM-stage data memory:
//   - default word/address widths (kept in step with the global core defines)
//   - controller state encoding
//   - byte-merge helper: old word, new word, byte enables -> merged word
// -----------------------------------------------------------------------------
package dmem_be_ctrl_pkg;

  localparam int DMEM_WORD_WIDTH = 32;
  localparam int DMEM_ADDR_WIDTH = 10;
  localparam int DMEM_BE_WIDTH   = DMEM_WORD_WIDTH / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } dmem_state_e;

  // Byte i of the result comes from new_w when be[i] is set, else from old_w.
  function automatic logic [DMEM_WORD_WIDTH-1:0] be_merge(
    input logic [DMEM_WORD_WIDTH-1:0] old_w,
    input logic [DMEM_WORD_WIDTH-1:0] new_w,
    input logic [DMEM_BE_WIDTH-1:0]   be
  );
    logic [DMEM_WORD_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < DMEM_BE_WIDTH; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_be_ctrl_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Plain synchronous single-port RAM, DEPTH x WORD_WIDTH, per-byte write
// enables and a registered read port. No reset on the storage or the read
// register; the controller owns initialisation and output qualification.
//   clk_i    in   clock
//   we_i     in   BE_WIDTH   per-byte write enables (byte i <- wdata_i byte i)
//   re_i     in   1          read enable; rdata_o updates on the next edge
//   addr_i   in   IDX_WIDTH  word index (caller guarantees < DEPTH)
//   wdata_i  in   WORD_WIDTH write data
//   rdata_o  out  WORD_WIDTH registered read data, holds when re_i is low
// -----------------------------------------------------------------------------
module dmem_array #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int BE_WIDTH  = WORD_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic [BE_WIDTH-1:0]   we_i,
  input  logic                  re_i,
  input  logic [IDX_WIDTH-1:0]  addr_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  output logic [WORD_WIDTH-1:0] rdata_o
);

  logic [WORD_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [WORD_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_be_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_be_ctrl
// MEM-stage data memory controller: byte-enabled writes, registered reads with
// a valid strobe, out-of-range detection and a sequential post-reset clear.
//   clk         in   clock, all state changes on the rising edge
//   rst         in   synchronous active-high reset
//   mem_write   in   write request
//   mem_read    in   read request (ignored when mem_write is also high)
//   mem_addr    in   ADDR_WIDTH word address
//   mem_be      in   BE_WIDTH byte enables for writes
//   mem_wdata   in   WORD_WIDTH write data
//   mem_ready   out  high in IDLE; requests are accepted only then
//   mem_rdata   out  registered read data, holds the last read value
//   mem_rvalid  out  one-cycle pulse, mem_rdata updated this cycle
//   mem_err     out  one-cycle pulse, previous accepted request out of range
//
// Handshake: a request is accepted on a rising edge where
// (mem_write | mem_read) & mem_ready is high; there is no back-pressure
// beyond mem_ready, and mem_rvalid/mem_err are single-cycle responses in the
// cycle after acceptance which the requester must capture immediately.
// -----------------------------------------------------------------------------
module dmem_be_ctrl
  import dmem_be_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH = DMEM_WORD_WIDTH,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DEPTH      = 1024,
  localparam int BE_WIDTH  = WORD_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [BE_WIDTH-1:0]   mem_be,
  input  logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  mem_ready,
  output logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  mem_rvalid,
  output logic                  mem_err
);

  localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_WIDTH-1:0] CLR_LAST = IDX_WIDTH'(DEPTH - 1);

  dmem_state_e           state_q, state_d;
  logic [IDX_WIDTH-1:0]  clr_cnt_q, clr_cnt_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;
  // Forces mem_rdata to zero: after reset and after an out-of-range read.
  // The RAM read register itself is never reset, so this flag qualifies it.
  logic                  zero_q, zero_d;

  logic                  addr_oor;
  logic [BE_WIDTH-1:0]   ram_we;
  logic                  ram_re;
  logic [IDX_WIDTH-1:0]  ram_addr;
  logic [WORD_WIDTH-1:0] ram_wdata;
  logic [WORD_WIDTH-1:0] ram_rdata;

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  assign addr_oor = ({1'b0, mem_addr} >= (ADDR_WIDTH+1)'(DEPTH));

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    zero_d    = zero_q;
    ram_we    = '0;
    ram_re    = 1'b0;
    ram_addr  = mem_addr[IDX_WIDTH-1:0];
    ram_wdata = mem_wdata;

    case (state_q)
      ST_CLEAR: begin
        // External requests are ignored; the port belongs to the clear engine.
        ram_we    = '1;
        ram_addr  = clr_cnt_q;
        ram_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end
      end
      ST_IDLE: begin
        if (mem_write) begin
          // Write wins over a simultaneous read; an all-zero mask is a no-op.
          if (!addr_oor) ram_we = mem_be;
          else           err_d  = |mem_be;
        end else if (mem_read) begin
          rvalid_d = 1'b1;
          if (addr_oor) begin
            err_d  = 1'b1;
            zero_d = 1'b1;
          end else begin
            ram_re = 1'b1;
            zero_d = 1'b0;
          end
        end
      end
    endcase

    // Keep the array untouched on a reset cycle.
    if (rst) begin
      ram_we = '0;
      ram_re = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      zero_q    <= zero_d;
    end
  end

  dmem_array #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_array (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign mem_ready  = (state_q == ST_IDLE);
  assign mem_rdata  = zero_q ? '0 : ram_rdata;
  assign mem_rvalid = rvalid_q;
  assign mem_err    = err_q;

endmodule
